// File: rtl/std_eth_fcs_append.sv
// Ethernet FCS appender: passes payload bytes through, optionally zero-pads short
// frames, then emits the 4-byte CRC32 (LSB byte first) with out_last on the final byte.

module std_crc #(
  parameter string TYPE = "ETH",
  parameter int    DW   = 8
) (
  input  logic [DW-1:0] data_in,
  input  logic [31:0]   crc_state,
  output logic [31:0]   crc_out
);
  // Reflected polynomial; CRC32C is kept as the only alternative flavour.
  localparam logic [31:0] POLY = (TYPE == "CASTAGNOLI") ? 32'h82F63B78 : 32'hEDB88320;

  always_comb begin
    crc_out = crc_state;
    for (int b = 0; b < DW; b++) begin
      if (crc_out[0] ^ data_in[b]) crc_out = (crc_out >> 1) ^ POLY;
      else                         crc_out = crc_out >> 1;
    end
  end
endmodule

module std_eth_fcs_append #(
  parameter int PAD     = 1,
  parameter int MIN_LEN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);
  typedef enum logic [1:0] {S_DATA, S_PAD, S_FCS} state_t;

  localparam logic [7:0]  MIN_B    = 8'(MIN_LEN);
  localparam logic        PAD_EN   = (PAD != 0);
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  state_t      state, state_nxt;
  logic [31:0] crc, crc_nxt;
  logic [7:0]  count, count_inc;
  logic [1:0]  idx;
  logic        out_fire;

  std_crc #(.TYPE("ETH"), .DW(8)) u_crc (
    .data_in   (out_data),
    .crc_state (crc),
    .crc_out   (crc_nxt)
  );

  assign count_inc = (count == 8'hFF) ? 8'hFF : count + 8'd1;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (state)
      S_DATA: begin
        out_data  = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        if (out_fire && in_last)
          state_nxt = (!PAD_EN || count_inc >= MIN_B) ? S_FCS : S_PAD;
      end
      S_PAD: begin
        out_valid = 1'b1;
        if (out_fire && count_inc >= MIN_B) state_nxt = S_FCS;
      end
      S_FCS: begin
        out_valid = 1'b1;
        out_data  = ~crc[{idx, 3'b000} +: 8];
        out_last  = (idx == 2'd3);
        if (out_fire && idx == 2'd3) state_nxt = S_DATA;
      end
      default: state_nxt = S_DATA;
    endcase
    // Handshake outputs are forced quiet while reset is held.
    if (reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_DATA;
      crc   <= CRC_INIT;
      count <= 8'd0;
      idx   <= 2'd0;
    end else if (out_fire) begin
      state <= state_nxt;
      if (state == S_FCS) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          crc   <= CRC_INIT;
          count <= 8'd0;
        end
      end else begin
        crc   <= crc_nxt;
        count <= count_inc;
      end
    end
  end
endmodule

// File: tb/tb_std_eth_fcs_append.sv
// Directed bench for std_eth_fcs_append: one unpadded and one padded instance share
// the stimulus; a select steers handshakes so only one instance carries each frame.

module tb_std_eth_fcs_append;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_last, out_ready, sel;
  logic       in_valid0, in_ready0, out_valid0, out_last0;
  logic       in_valid1, in_ready1, out_valid1, out_last1;
  logic [7:0] out_data0, out_data1;
  logic       in_ready_m, out_valid_m, out_last_m;
  logic [7:0] out_data_m;

  int n_chk = 0, n_err = 0, cyc = 0;
  logic       rand_rdy = 1'b0;
  logic [7:0] pay [0:511];
  logic [8:0] exp_q[$], rx_q[$], rx_sv[$];
  int         cyc_q[$], cyc_sv[$];
  logic [7:0] hand [0:12] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                              8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid0   = in_valid & ~sel;
  assign in_valid1   = in_valid & sel;
  assign in_ready_m  = sel ? in_ready1  : in_ready0;
  assign out_valid_m = sel ? out_valid1 : out_valid0;
  assign out_last_m  = sel ? out_last1  : out_last0;
  assign out_data_m  = sel ? out_data1  : out_data0;

  std_eth_fcs_append #(.PAD(0), .MIN_LEN(60)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid0), .in_last(in_last),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0), .out_last(out_last0),
    .out_ready(out_ready));

  std_eth_fcs_append #(.PAD(1), .MIN_LEN(60)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1), .in_last(in_last),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1),
    .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: record every output transfer and check that a stalled output holds.
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1, psel = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (pv && !pr && !prst && !reset && psel == sel) begin
      chk("hold_valid", 32'(out_valid_m), 32'd1);
      chk("hold_data", 32'(out_data_m), 32'(pd));
    end
    if (!reset && out_valid_m && out_ready) begin
      rx_q.push_back({out_last_m, out_data_m});
      cyc_q.push_back(cyc);
    end
    pv = out_valid_m; pr = out_ready; pd = out_data_m; prst = reset; psel = sel;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Expected stream: payload, zero pad on the padded instance, reflected CRC32 LSB first.
  task automatic build_exp(input logic s, input int len);
    int tot = (s && len < 60) ? 60 : len;
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0]  b;
    for (int i = 0; i < tot; i++) begin
      b = (i < len) ? pay[i] : 8'h00;
      exp_q.push_back({1'b0, b});
      c = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, c[8*k +: 8]});
  endtask

  // Starts and ends half a tick past a rising edge.
  task automatic send_frame(input logic s, input int len, input logic gaps);
    int t;
    sel = s;
    build_exp(s, len);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1; in_data = pay[i]; in_last = (i == len - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready_m) break;
        if (++t > 3000) begin chk("in_timeout", 32'(t), 32'd0); break; end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input string tag, input logic per_byte);
    int t = 0, bad = -1;
    while (rx_q.size() < exp_q.size() && t < 6000) begin @(negedge clk); t++; end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      if (per_byte) chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      else if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    end
    if (!per_byte) chk({tag, "_first_bad"}, 32'(bad), 32'hFFFFFFFF);
    rx_sv = rx_q; cyc_sv = cyc_q;
    rx_q.delete(); cyc_q.delete(); exp_q.delete();
  endtask

  task automatic load_digits();
    string s = "123456789";
    for (int i = 0; i < 9; i++) pay[i] = s[i];
  endtask

  task automatic check_hand(input string tag, input int base);
    for (int i = 0; i < 13; i++)
      chk(tag, 32'(rx_sv[base + i]), 32'({i == 12, hand[i]}));
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = 8'hA5; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_ready0", 32'(in_ready0), 32'd0);
    chk("rst_last0", 32'(out_last0), 32'd0);
    sel = 1'b1; #1;
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_ready1", 32'(in_ready1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; sel = 1'b0;
    @(posedge clk); #1;

    // Check value "123456789" without padding.
    load_digits();
    send_frame(1'b0, 9, 1'b0);
    drain("digits", 1'b1);
    check_hand("digits_hand", 0);

    // Back-to-back: next frame's first byte lands the cycle after out_last.
    send_frame(1'b0, 9, 1'b0);
    send_frame(1'b0, 9, 1'b0);
    drain("b2b", 1'b1);
    check_hand("b2b_hand", 13);
    chk("b2b_gap", 32'(cyc_sv[13] - cyc_sv[12]), 32'd1);

    // Single zero byte padded to 60, then FCS: 64 transfers.
    pay[0] = 8'h00;
    send_frame(1'b1, 1, 1'b0);
    drain("pad1", 1'b1);
    chk("pad1_count", 32'(rx_sv.size()), 32'd64);

    // 60 and 61 byte frames get no padding.
    for (int i = 0; i < 61; i++) pay[i] = 8'(i * 7 + 3);
    send_frame(1'b1, 60, 1'b0);
    drain("len60", 1'b1);
    chk("len60_count", 32'(rx_sv.size()), 32'd64);
    send_frame(1'b1, 61, 1'b0);
    drain("len61", 1'b1);
    chk("len61_count", 32'(rx_sv.size()), 32'd65);

    // Random frames with random backpressure and input gaps, incl. >255-byte frames.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len = (f % 10 == 9) ? $urandom_range(256, 300) : $urandom_range(1, 90);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      send_frame(1'($urandom_range(1)), len, 1'b1);
      drain("rand", 1'b0);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset while padding.
    pay[0] = 8'h5A;
    send_frame(1'b1, 1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_pad_data", 32'(out_data1), 32'd0);
    chk("pre_rst_pad_valid", 32'(out_valid1), 32'd1);
    reset = 1'b1; #2;
    chk("rst_pad_valid", 32'(out_valid1), 32'd0);
    chk("rst_pad_last", 32'(out_last1), 32'd0);
    chk("rst_pad_ready", 32'(in_ready1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rx_q.delete(); cyc_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    load_digits();
    send_frame(1'b1, 9, 1'b0);
    drain("after_pad_rst", 1'b1);

    // Reset while FCS byte 2 is on the output.
    send_frame(1'b0, 9, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_fcs2", 32'(out_data0), 32'h0000_00F4);
    reset = 1'b1; #2;
    chk("rst_fcs_valid", 32'(out_valid0), 32'd0);
    chk("rst_fcs_last", 32'(out_last0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rx_q.delete(); cyc_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    send_frame(1'b0, 9, 1'b0);
    drain("after_fcs_rst", 1'b1);
    check_hand("after_fcs_rst_hand", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
